// File: rtl/osc_meas_sequencer.sv
// Oscillator measurement sequencer: host-visible GO/STAT/DIV/LIMIT/RESULT registers,
// and an OPB master that drives the oscillator counter through one full measurement.
module osc_meas_sequencer #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd4000000,
  parameter logic [15:0] DEF_DIV     = 16'd1000
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [1:0]  OPB_ADDR,
  input  logic [31:0] OPB_DI,
  output logic [31:0] OPB_DO,
  input  logic        OPB_RE,
  input  logic        OPB_WE,
  output logic [1:0]  CNT_ADDR,
  output logic [31:0] CNT_DO,
  input  logic [31:0] CNT_DI,
  output logic        CNT_RE,
  output logic        CNT_WE,
  output logic        MEAS_DONE
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_DIV    = 3'd1,
    WR_RST    = 3'd2,
    POLL_RST  = 3'd3,
    WR_GO     = 3'd4,
    POLL_BUSY = 3'd5,
    RD_CNT    = 3'd6,
    EVAL      = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic        kill_q, kill_d;
  logic        killAbort_q, killAbort_d;
  logic [23:0] timer_q, timer_d;
  logic [15:0] div_q, div_d;
  logic [31:0] limit_q, limit_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic        aborted_q, aborted_d;

  logic busy, goCmd, abortCmd, timerLast;
  logic unusedCntHi;

  assign busy        = (state_q != IDLE);
  assign goCmd       = OPB_WE && (OPB_ADDR == 2'd0) && OPB_DI[0];
  assign abortCmd    = OPB_WE && (OPB_ADDR == 2'd0) && OPB_DI[1];
  assign timerLast   = (timer_q == TIMEOUT_CYC - 24'd1);
  assign unusedCntHi = ^CNT_DI[31:16];

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      killAbort_q <= 1'b0;
      timer_q     <= '0;
      div_q       <= DEF_DIV;
      limit_q     <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      killAbort_q <= killAbort_d;
      timer_q     <= timer_d;
      div_q       <= div_d;
      limit_q     <= limit_d;
      result_q    <= result_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      aborted_q   <= aborted_d;
    end
  end

  // kill_q marks the single error-exit cycle: it overrides the pending state access
  // with a counter reset write and closes the measurement as aborted or timed out.
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    killAbort_d = killAbort_q;
    timer_d     = timer_q;
    div_d       = div_q;
    limit_d     = limit_q;
    result_d    = result_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    aborted_d   = aborted_q;
    CNT_ADDR    = 2'd0;
    CNT_DO      = '0;
    CNT_RE      = 1'b0;
    CNT_WE      = 1'b0;
    MEAS_DONE   = 1'b0;

    if (OPB_WE && !busy && (OPB_ADDR == 2'd1)) div_d = OPB_DI[15:0];
    if (OPB_WE && !busy && (OPB_ADDR == 2'd2)) limit_d = OPB_DI;

    if (kill_q) begin
      CNT_WE    = 1'b1;
      CNT_DO    = 32'h2;
      MEAS_DONE = 1'b1;
      state_d   = IDLE;
      kill_d    = 1'b0;
      done_d    = 1'b1;
      pass_d    = 1'b0;
      if (killAbort_q) aborted_d = 1'b1;
      else             timeout_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (goCmd && !abortCmd) begin
            done_d    = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            aborted_d = 1'b0;
            timer_d   = '0;
            state_d   = WR_DIV;
          end
        end
        WR_DIV: begin
          CNT_WE   = 1'b1;
          CNT_ADDR = 2'd1;
          CNT_DO   = {16'b0, div_q};
          state_d  = WR_RST;
        end
        WR_RST: begin
          CNT_WE  = 1'b1;
          CNT_DO  = 32'h2;
          timer_d = '0;
          state_d = POLL_RST;
        end
        POLL_RST: begin
          CNT_RE = 1'b1;
          if (!CNT_DI[1]) begin
            state_d = WR_GO;
          end else if (timerLast) begin
            kill_d      = 1'b1;
            killAbort_d = 1'b0;
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
        WR_GO: begin
          CNT_WE  = 1'b1;
          CNT_DO  = 32'h1;
          timer_d = '0;
          state_d = POLL_BUSY;
        end
        POLL_BUSY: begin
          // The first read after GO can still show idle, so at least two reads are required.
          CNT_RE = 1'b1;
          if ((timer_q != 24'd0) && !CNT_DI[2]) begin
            state_d = RD_CNT;
          end else if (timerLast) begin
            kill_d      = 1'b1;
            killAbort_d = 1'b0;
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
        RD_CNT: begin
          CNT_RE   = 1'b1;
          CNT_ADDR = 2'd2;
          result_d = {16'b0, CNT_DI[15:0]};
          state_d  = EVAL;
        end
        EVAL: begin
          pass_d    = (result_q[15:0] >= limit_q[15:0]) && (result_q[15:0] <= limit_q[31:16]);
          done_d    = 1'b1;
          MEAS_DONE = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // EVAL already signals completion this cycle, so an abort there is too late to matter.
      if (abortCmd && busy && (state_q != EVAL)) begin
        kill_d      = 1'b1;
        killAbort_d = 1'b1;
        state_d     = state_q;
      end
    end
  end

  always_comb begin
    OPB_DO = '0;
    if (OPB_RE) begin
      case (OPB_ADDR)
        2'd0:    OPB_DO = {24'b0, state_q, aborted_q, timeout_q, pass_q, done_q, busy};
        2'd1:    OPB_DO = {16'b0, div_q};
        2'd2:    OPB_DO = limit_q;
        default: OPB_DO = result_q;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_meas_sequencer.sv
// Bench for osc_meas_sequencer: behavioural counter peripheral plus a scoreboard of
// expected counter writes, with one task per scenario.
module tb_osc_meas_sequencer;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST = 1'b1;
  logic [1:0]  OPB_ADDR = 2'd0;
  logic [31:0] OPB_DI = '0;
  logic [31:0] OPB_DO;
  logic        OPB_RE = 1'b0;
  logic        OPB_WE = 1'b0;
  logic [1:0]  CNT_ADDR;
  logic [31:0] CNT_DO;
  logic [31:0] CNT_DI;
  logic        CNT_RE;
  logic        CNT_WE;
  logic        MEAS_DONE;

  osc_meas_sequencer #(.TIMEOUT_CYC(24'd64), .DEF_DIV(16'd1000)) dut (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .OPB_ADDR(OPB_ADDR), .OPB_DI(OPB_DI),
    .OPB_DO(OPB_DO), .OPB_RE(OPB_RE), .OPB_WE(OPB_WE), .CNT_ADDR(CNT_ADDR),
    .CNT_DO(CNT_DO), .CNT_DI(CNT_DI), .CNT_RE(CNT_RE), .CNT_WE(CNT_WE),
    .MEAS_DONE(MEAS_DONE)
  );

  always #15 OPB_CLK = ~OPB_CLK;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t expWr[$];
  int  checks = 0;
  int  errors = 0;
  int  accessCount = 0;
  int  doneCount = 0;
  int  pollReads = 0;

  // Counter peripheral model configuration, driven from the stimulus tasks.
  int          busyReadsCfg = 20;
  bit          stuckMode = 1'b0;
  logic [31:0] modelCount = '0;

  int rstLeft;
  int busyLeft;

  always_comb begin
    CNT_DI = '0;
    if (CNT_RE) begin
      if (CNT_ADDR == 2'd0) CNT_DI = {29'b0, busyLeft != 0, rstLeft != 0, 1'b0};
      else if (CNT_ADDR == 2'd2) CNT_DI = modelCount;
    end
  end

  always @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      rstLeft  <= 0;
      busyLeft <= 0;
    end else if (CNT_WE && CNT_ADDR == 2'd0) begin
      if (CNT_DO == 32'h2) begin
        rstLeft  <= 2;
        busyLeft <= 0;
      end else if (CNT_DO == 32'h1) begin
        busyLeft <= stuckMode ? 32'h7fff_ffff : busyReadsCfg;
      end
    end else if (CNT_RE && CNT_ADDR == 2'd0) begin
      if (rstLeft > 0) rstLeft <= rstLeft - 1;
      if (busyLeft > 0 && !stuckMode) busyLeft <= busyLeft - 1;
    end
  end

  // Bus monitor: pops the write scoreboard and tallies accesses and pulses.
  always @(negedge OPB_CLK) begin
    wr_t e;
    if (CNT_RE && CNT_WE) begin
      errors++;
      $display("[TB] FAIL strobe_overlap: CNT_RE=%b CNT_WE=%b, required never both 1", CNT_RE, CNT_WE);
    end
    if (CNT_RE || CNT_WE) accessCount++;
    if (MEAS_DONE) doneCount++;
    if (CNT_RE && CNT_ADDR == 2'd0) pollReads++;
    if (CNT_WE) begin
      if (CNT_ADDR == 2'd0 && CNT_DO == 32'h1) pollReads = 0;
      checks++;
      if (expWr.size() == 0) begin
        errors++;
        $display("[TB] FAIL cnt_write: unexpected write addr=%0d data=%h", CNT_ADDR, CNT_DO);
      end else begin
        e = expWr.pop_front();
        if ({CNT_ADDR, CNT_DO} !== {e.a, e.d}) begin
          errors++;
          $display("[TB] FAIL cnt_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   CNT_ADDR, CNT_DO, e.a, e.d);
        end
      end
    end
  end

  task automatic hostWrite(input logic [1:0] a, input logic [31:0] d);
    @(negedge OPB_CLK);
    OPB_ADDR = a;
    OPB_DI   = d;
    OPB_WE   = 1'b1;
    @(negedge OPB_CLK);
    OPB_WE   = 1'b0;
  endtask

  task automatic hostRead(input logic [1:0] a, output logic [31:0] d);
    @(negedge OPB_CLK);
    OPB_ADDR = a;
    OPB_RE   = 1'b1;
    #1;
    d = OPB_DO;
    OPB_RE = 1'b0;
  endtask

  task automatic pushWr(input logic [1:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    expWr.push_back(e);
  endtask

  task automatic waitDone(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge OPB_CLK);
      if (MEAS_DONE) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic checkReg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    hostRead(a, v);
    checks++;
    if (v !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, v, exp);
    end
  endtask

  task automatic runMeas(input string name, input logic [15:0] div, input logic [31:0] limit,
                         input logic [31:0] count, input bit expPass);
    bit ok;
    int d0;
    hostWrite(2'd1, {16'b0, div});
    hostWrite(2'd2, limit);
    stuckMode    = 1'b0;
    busyReadsCfg = 20;
    modelCount   = count;
    pushWr(2'd1, {16'b0, div});
    pushWr(2'd0, 32'h2);
    pushWr(2'd0, 32'h1);
    d0 = doneCount;
    hostWrite(2'd0, 32'h1);
    waitDone(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s_done_wait: MEAS_DONE not seen within 2000 cycles", name);
    end
    repeat (4) @(negedge OPB_CLK);
    checks++;
    if (doneCount - d0 != 1) begin
      errors++;
      $display("[TB] FAIL %s_pulses: got %0d MEAS_DONE pulses, expected 1", name, doneCount - d0);
    end
    checks++;
    if (expWr.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_writes: %0d expected counter writes missing", name, expWr.size());
      expWr.delete();
    end
    checks++;
    if (pollReads != 21) begin
      errors++;
      $display("[TB] FAIL %s_polls: got %0d busy polls, expected 21", name, pollReads);
    end
    checkReg({name, "_result"}, 2'd3, {16'b0, count[15:0]});
    checkReg({name, "_stat"}, 2'd0, expPass ? 32'h6 : 32'h2);
  endtask

  task automatic test_reset;
    OPB_RST = 1'b1;
    repeat (3) @(negedge OPB_CLK);
    checks++;
    if ({CNT_RE, CNT_WE, MEAS_DONE} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got %b, expected 000", {CNT_RE, CNT_WE, MEAS_DONE});
    end
    OPB_RST = 1'b0;
    checkReg("reset_stat", 2'd0, 32'h0);
    checkReg("reset_div", 2'd1, 32'd1000);
    checkReg("reset_limit", 2'd2, 32'h0);
    checkReg("reset_result", 2'd3, 32'h0);
  endtask

  task automatic test_measure;
    runMeas("pass650", 16'd500, {16'd700, 16'd600}, 32'hABCD_028A, 1'b1);
    runMeas("fail701", 16'd500, {16'd700, 16'd600}, 32'h0000_02BD, 1'b0);
    runMeas("pass600", 16'd500, {16'd700, 16'd600}, 32'h1234_0258, 1'b1);
    runMeas("pass700", 16'd77, {16'd700, 16'd600}, 32'h0000_02BC, 1'b1);
    runMeas("lo_gt_hi", 16'd500, {16'd600, 16'd700}, 32'h0000_028A, 1'b0);
  endtask

  task automatic test_timeout;
    bit ok;
    int d0;
    stuckMode = 1'b1;
    pushWr(2'd1, 32'd500);
    pushWr(2'd0, 32'h2);
    pushWr(2'd0, 32'h1);
    pushWr(2'd0, 32'h2);
    d0 = doneCount;
    hostWrite(2'd0, 32'h1);
    waitDone(500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL timeout_wait: MEAS_DONE not seen within 500 cycles");
    end
    repeat (3) @(negedge OPB_CLK);
    checks++;
    if (pollReads != 64) begin
      errors++;
      $display("[TB] FAIL timeout_polls: got %0d polls, expected 64", pollReads);
    end
    checks++;
    if (doneCount - d0 != 1 || expWr.size() != 0) begin
      errors++;
      $display("[TB] FAIL timeout_seq: pulses=%0d pending_writes=%0d, expected 1 and 0",
               doneCount - d0, expWr.size());
      expWr.delete();
    end
    checkReg("timeout_stat", 2'd0, 32'h0A);
    checkReg("timeout_result", 2'd3, 32'd650);
  endtask

  task automatic test_abort;
    int d0;
    stuckMode = 1'b1;
    pushWr(2'd1, 32'd500);
    pushWr(2'd0, 32'h2);
    pushWr(2'd0, 32'h1);
    d0 = doneCount;
    hostWrite(2'd0, 32'h1);
    repeat (20) @(negedge OPB_CLK);
    checkReg("abort_busy_stat", 2'd0, 32'hA1);
    hostWrite(2'd1, 32'd123);
    pushWr(2'd0, 32'h2);
    hostWrite(2'd0, 32'h2);
    checks++;
    if ({CNT_WE, CNT_RE, CNT_ADDR, CNT_DO, MEAS_DONE} !== {1'b1, 1'b0, 2'd0, 32'h2, 1'b1}) begin
      errors++;
      $display("[TB] FAIL abort_kill_cycle: WE=%b RE=%b addr=%0d data=%h done=%b, expected 1 0 0 2 1",
               CNT_WE, CNT_RE, CNT_ADDR, CNT_DO, MEAS_DONE);
    end
    repeat (3) @(negedge OPB_CLK);
    checkReg("abort_stat", 2'd0, 32'h12);
    checkReg("abort_div_locked", 2'd1, 32'd500);
    checks++;
    if (doneCount - d0 != 1 || expWr.size() != 0) begin
      errors++;
      $display("[TB] FAIL abort_seq: pulses=%0d pending_writes=%0d, expected 1 and 0",
               doneCount - d0, expWr.size());
      expWr.delete();
    end
  endtask

  task automatic test_go_abort_idle;
    int a0;
    stuckMode = 1'b0;
    a0 = accessCount;
    hostWrite(2'd0, 32'h3);
    repeat (10) @(negedge OPB_CLK);
    checks++;
    if (accessCount != a0) begin
      errors++;
      $display("[TB] FAIL go_abort_idle: got %0d counter accesses, expected 0", accessCount - a0);
    end
    checkReg("go_abort_stat", 2'd0, 32'h12);
  endtask

  task automatic test_reset_midrun;
    bit found;
    stuckMode    = 1'b0;
    busyReadsCfg = 20;
    modelCount   = 32'd650;
    pushWr(2'd1, 32'd500);
    pushWr(2'd0, 32'h2);
    pushWr(2'd0, 32'h1);
    hostWrite(2'd0, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge OPB_CLK);
      if (CNT_RE && CNT_ADDR == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL midrun_reach_rdcnt: count read not seen within 300 cycles");
    end
    #2;
    OPB_RST = 1'b1;
    #1;
    checks++;
    if ({CNT_RE, CNT_WE, MEAS_DONE, CNT_ADDR, CNT_DO} !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_async_reset: RE=%b WE=%b done=%b addr=%0d data=%h, expected all 0",
               CNT_RE, CNT_WE, MEAS_DONE, CNT_ADDR, CNT_DO);
    end
    expWr.delete();
    @(negedge OPB_CLK);
    OPB_RST = 1'b0;
    checkReg("midrun_div", 2'd1, 32'd1000);
    checkReg("midrun_result", 2'd3, 32'd0);
    runMeas("after_reset", 16'd1000, {16'd700, 16'd600}, 32'h0000_028A, 1'b1);
  endtask

  initial begin
    test_reset();
    test_measure();
    test_timeout();
    test_abort();
    test_go_abort_idle();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
